adder_entry_sequencer: RTL and testbench

Operand-entry and accumulation controller that feeds the 7-segment display stage. It debounces a single load key, captures two 4-bit operands from the switches, and forms their 5-bit sum. Further key presses accumulate more switch values into the running sum until it would exceed 31, at which point it raises the overflow flag. Outputs connect directly to the display stage's operand A, operand B, sum and overflow inputs.

---
 rtl/adder_entry_sequencer.sv | 101 ++++++++++
 tb/tb_adder_entry_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/adder_entry_sequencer.sv
// adder_entry_sequencer: debounced two-operand entry and saturating accumulator; ADDER_ENTRY_KEY_SYNC_EN adds a 2-flop key synchroniser
module adder_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_load,
  input  logic       clr,
  input  logic [3:0] sw,
  output logic [3:0] inputA,
  output logic [3:0] inputB,
  output logic [4:0] outputSum,
  output logic       cout,
  output logic [1:0] phase
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {GET_A, GET_B, SHOW, FULL} state_t;
  state_t state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [4:0] sum_q, sum_d;
  logic cout_q, cout_d;
  logic key_s, lvl_q, lvl_d, lvl_prev_q, press, hit;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [5:0] t;
`ifdef ADDER_ENTRY_KEY_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= reset ? 2'b00 : {sync_q[0], key_load};
  assign key_s = sync_q[1];
`else
  assign key_s = key_load;
`endif
  // Any cycle where the key matches the accepted level restarts the stability count
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    hit = (key_s != lvl_q) && (cnt_inc == CW'(DEBOUNCE_CYCLES));
    cnt_d = (key_s == lvl_q || hit) ? '0 : cnt_inc;
    lvl_d = hit ? ~lvl_q : lvl_q;
  end
  assign press = lvl_q & ~lvl_prev_q;
  assign t = {1'b0, sum_q} + {2'b00, sw};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    cout_d = cout_q;
    if (clr) begin
      state_d = GET_A;
      a_d = '0;
      b_d = '0;
      sum_d = '0;
      cout_d = 1'b0;
    end else if (press) begin
      case (state_q)
        GET_A: begin
          a_d = sw;
          state_d = GET_B;
        end
        GET_B: begin
          b_d = sw;
          sum_d = {1'b0, a_q} + {1'b0, sw};
          state_d = SHOW;
        end
        SHOW: begin
          cout_d = t[5];
          state_d = t[5] ? FULL : SHOW;
          sum_d = t[5] ? sum_q : t[4:0];
          b_d = t[5] ? b_q : sw;
        end
        default: state_d = FULL;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GET_A;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      lvl_q <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      lvl_q <= lvl_d;
      lvl_prev_q <= lvl_q;
      cnt_q <= cnt_d;
    end
  end
  assign inputA = a_q;
  assign inputB = b_q;
  assign outputSum = sum_q;
  assign cout = cout_q;
  assign phase = state_q;
endmodule

// File: tb/tb_adder_entry_sequencer.sv
// tb_adder_entry_sequencer: directed presses with a queue of expected output changes and their edge numbers
module tb_adder_entry_sequencer;
  localparam int N = 4;
`ifdef ADDER_ENTRY_KEY_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  typedef struct {
    logic [15:0] v;
    int e;
  } exp_t;
  logic clk = 0, reset = 1, key_load = 0, clr = 0;
  logic [3:0] sw = 0, inputA, inputB;
  logic [4:0] outputSum;
  logic cout;
  logic [1:0] phase;
  logic [15:0] cur, prev;
  exp_t q[$];
  exp_t e;
  int cyc = 0, checks = 0, errors = 0;
  bit en = 0;
  adder_entry_sequencer #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .key_load(key_load), .clr(clr), .sw(sw),
    .inputA(inputA), .inputB(inputB), .outputSum(outputSum), .cout(cout), .phase(phase)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cur = {phase, inputA, inputB, outputSum, cout};
  function automatic logic [15:0] pk(input int ph, a, b, s, c);
    return {2'(ph), 4'(a), 4'(b), 5'(s), 1'(c)};
  endfunction
  always @(negedge clk) begin
    if (en && cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change edge %0d: got %h, required no change from %h", cyc, cur, prev);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || cyc != e.e) begin
          errors++;
          $display("FAIL change: got %h at edge %0d, required %h at edge %0d", cur, cyc, e.v, e.e);
        end
      end
      prev = cur;
    end
  end
  task automatic chk(input string name, input logic [15:0] v);
    checks++;
    if (cur !== v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, cur, v);
    end
  endtask
  task automatic press(input logic [3:0] s, input bit chg, input logic [15:0] v);
    @(posedge clk); #1;
    key_load = 1;
    sw = s;
    if (chg) q.push_back('{v, cyc + N + 1 + LAT});
    repeat (N + LAT + 4) @(posedge clk);
    #1 key_load = 0;
    repeat (N + LAT + 4) @(posedge clk);
  endtask
  task automatic pulse(input int len, input bit chg, input logic [15:0] v);
    @(posedge clk); #1;
    key_load = 1;
    if (chg) q.push_back('{v, cyc + N + 1 + LAT});
    repeat (len) @(posedge clk);
    #1 key_load = 0;
    repeat (N + LAT + 4) @(posedge clk);
  endtask
  task automatic do_clr(input logic [15:0] v);
    @(posedge clk); #1;
    clr = 1;
    q.push_back('{v, cyc + 1});
    @(posedge clk); #1;
    clr = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("reset_state", pk(0, 0, 0, 0, 0));
    prev = cur;
    en = 1;
    press(9, 1, pk(1, 9, 0, 0, 0));
    do_clr(pk(0, 0, 0, 0, 0));
    press(7, 1, pk(1, 7, 0, 0, 0));
    press(6, 1, pk(2, 7, 6, 13, 0));
    press(15, 1, pk(2, 7, 15, 28, 0));
    press(3, 1, pk(2, 7, 3, 31, 0));
    press(1, 1, pk(3, 7, 3, 31, 1));
    press(5, 0, '0);
    chk("full_ignores_press", pk(3, 7, 3, 31, 1));
    do_clr(pk(0, 0, 0, 0, 0));
    sw = 2;
    pulse(3, 0, '0);
    chk("glitch_3_cycles", pk(0, 0, 0, 0, 0));
    pulse(4, 1, pk(1, 2, 0, 0, 0));
    // clr lands on the same edge the press would update outputs
    @(posedge clk); #1;
    key_load = 1;
    sw = 11;
    repeat (N + LAT) @(posedge clk);
    #1 clr = 1;
    q.push_back('{pk(0, 0, 0, 0, 0), cyc + 1});
    @(posedge clk); #1;
    clr = 0;
    repeat (4) @(posedge clk);
    #1 key_load = 0;
    repeat (N + LAT + 4) @(posedge clk);
    chk("clr_beats_press", pk(0, 0, 0, 0, 0));
    press(4, 1, pk(1, 4, 0, 0, 0));
    @(posedge clk); #1;
    key_load = 1;
    sw = 8;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    q.push_back('{pk(0, 0, 0, 0, 0), cyc + 1});
    @(posedge clk); #1;
    reset = 0;
    q.push_back('{pk(1, 8, 0, 0, 0), cyc + N + 1 + LAT});
    repeat (N + LAT + 6) @(posedge clk);
    #1 key_load = 0;
    repeat (N + LAT + 6) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: got %0d outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
